fifo_wr_arbiter: RTL

Single-clock controller that shares one fifo memory write port between NUM_REQ producers, using round-robin arbitration with optional burst lock.
- Owns the binary write/read pointers and the full/empty/count state.
- Drives the memory's w_en, b_wptr, b_rptr, data_in, full and empty pins.
- Sequences consumer reads and flags valid read data.
- Sits between producer agents and the memory instance, with both memory clocks tied to clk.

---
 rtl/fifo_arb_pkg.sv | 39 +++
 rtl/rr_arbiter.sv | 22 ++
 rtl/fifo_wr_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and the round-robin pick function for fifo_wr_arbiter.
package fifo_arb_pkg;

    typedef enum logic {ARB, LOCK} arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DEPTH      = 256;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_PTR_WIDTH  = 8;
    localparam int unsigned DEF_BURST_MAX  = 4;

    localparam int unsigned MAX_REQ   = 8;
    localparam int unsigned MAX_IDX_W = 3;
    localparam int unsigned BEAT_W    = 4;

    // One-hot grant for the first set bit of req at or above rr_ptr, wrapping within n.
    function automatic logic [MAX_REQ-1:0] rr_pick(
        input logic [MAX_REQ-1:0]   req,
        input logic [MAX_IDX_W-1:0] rr_ptr,
        input int unsigned          n
    );
        logic [MAX_REQ-1:0]   g;
        logic [MAX_IDX_W-1:0] sel;
        logic                 found;
        g     = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < MAX_REQ; k++) begin
            if (k < n && !found) begin
                sel = MAX_IDX_W'((32'(rr_ptr) + k) % n);
                if (req[sel]) begin
                    g[sel] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
        return g;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick from a request vector and a rotating priority pointer.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ = DEF_NUM_REQ,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] gnt
);

    logic [MAX_REQ-1:0] req_ext;
    logic [MAX_REQ-1:0] pick;
    logic               unused_pick;

    assign req_ext     = MAX_REQ'(req);
    assign pick        = rr_pick(req_ext, MAX_IDX_W'(rr_ptr), NUM_REQ);
    assign gnt         = pick[NUM_REQ-1:0];
    assign unused_pick = ^pick;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Shares one fifo write port between NUM_REQ producers (round-robin + burst lock) and sequences reads.
// Optional macro FIFO_WR_ARB_WATERMARK_EN adds afull_thresh/almost_full and refuses new locks when almost full.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter int unsigned DEPTH      = DEF_DEPTH,
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PTR_WIDTH  = DEF_PTR_WIDTH,
    parameter int unsigned BURST_MAX  = DEF_BURST_MAX
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ-1:0]            req_lock,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            gnt,
    input  logic                          rd_req,
    output logic                          rd_valid,
    output logic                          w_en,
    output logic                          r_en,
    output logic [PTR_WIDTH:0]            b_wptr,
    output logic [PTR_WIDTH:0]            b_rptr,
    output logic [DATA_WIDTH-1:0]         data_in,
    output logic                          full,
    output logic                          empty,
    output logic [PTR_WIDTH:0]            count,
`ifdef FIFO_WR_ARB_WATERMARK_EN
    input  logic [PTR_WIDTH:0]            afull_thresh,
    output logic                          almost_full,
`endif
    output logic                          wr_drop
);

    localparam int unsigned IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

    if (DEPTH != (1 << PTR_WIDTH)) begin : g_depth_check
        $error("DEPTH must equal 2**PTR_WIDTH");
    end

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [BEAT_W-1:0]    beat_q, beat_d;
    logic [PTR_WIDTH:0]   wptr_q, wptr_d, rptr_q, rptr_d, count_q;
    logic                 full_q, empty_q, rd_valid_q;
    logic [NUM_REQ-1:0]   rr_gnt, gnt_raw;
    logic [IDX_W-1:0]     winner;
    logic                 lock_ok;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .IDX_W  (IDX_W)
    ) u_rr (
        .req   (req),
        .rr_ptr(rr_ptr_q),
        .gnt   (rr_gnt)
    );

    always_comb begin
        gnt_raw = '0;
        if (state_q == ARB) begin
            gnt_raw = rr_gnt;
        end else if (req[owner_q]) begin
            gnt_raw[owner_q] = 1'b1;
        end
        gnt = (rst_n && !full_q) ? gnt_raw : '0;
    end

    always_comb begin
        winner = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) winner = IDX_W'(i);
        end
    end

    assign w_en     = |(req & gnt);
    assign data_in  = req_data[winner*DATA_WIDTH +: DATA_WIDTH];
    assign r_en     = rst_n & rd_req & ~empty_q;
    assign wr_drop  = rst_n & (|req) & full_q;
    assign rd_valid = rd_valid_q;
    assign b_wptr   = wptr_q;
    assign b_rptr   = rptr_q;
    assign full     = full_q;
    assign empty    = empty_q;
    assign count    = count_q;

`ifdef FIFO_WR_ARB_WATERMARK_EN
    logic almost_full_q;
    assign almost_full = almost_full_q;
    assign lock_ok     = ~almost_full_q;
`else
    assign lock_ok     = 1'b1;
`endif

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        beat_d   = beat_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ARB: begin
                if (w_en) begin
                    rr_ptr_d = (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                    // A cap of one beat never needs the LOCK state.
                    if (req_lock[winner] && lock_ok && BURST_MAX > 1) begin
                        state_d = LOCK;
                        owner_d = winner;
                        beat_d  = BEAT_W'(1);
                    end
                end
            end
            LOCK: begin
                if (!req_lock[owner_q] || !req[owner_q]) begin
                    state_d = ARB;
                    beat_d  = '0;
                end else if (w_en) begin
                    beat_d = beat_q + 1'b1;
                    if (beat_d == BEAT_W'(BURST_MAX)) begin
                        state_d = ARB;
                        beat_d  = '0;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    always_comb begin
        wptr_d = wptr_q + (PTR_WIDTH + 1)'(w_en);
        rptr_d = rptr_q + (PTR_WIDTH + 1)'(r_en);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rr_ptr_q   <= '0;
            owner_q    <= '0;
            beat_q     <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            count_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            owner_q    <= owner_d;
            beat_q     <= beat_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            count_q    <= wptr_d - rptr_d;
            full_q     <= (wptr_d[PTR_WIDTH] != rptr_d[PTR_WIDTH]) &&
                          (wptr_d[PTR_WIDTH-1:0] == rptr_d[PTR_WIDTH-1:0]);
            empty_q    <= (wptr_d == rptr_d);
            rd_valid_q <= r_en;
        end
    end

`ifdef FIFO_WR_ARB_WATERMARK_EN
    always_ff @(posedge clk) begin
        if (!rst_n) almost_full_q <= 1'b0;
        else        almost_full_q <= ((wptr_d - rptr_d) >= afull_thresh);
    end
`endif

endmodule
